// File: rtl/apb_reg_pkg.sv
// -----------------------------------------------------------------------------
// apb_reg_pkg
// Shared definitions for the aligner APB register block: register offsets,
// field positions, reset values, the APB completer state type and the CTRL
// legality check.
// -----------------------------------------------------------------------------
package apb_reg_pkg;

    // Register byte offsets
    localparam logic [15:0] CTRL_OFF   = 16'h0000;
    localparam logic [15:0] STATUS_OFF = 16'h000C;
    localparam logic [15:0] IRQEN_OFF  = 16'h00F0;
    localparam logic [15:0] IRQ_OFF    = 16'h00F4;

    // CTRL fields
    localparam int CTRL_SIZE_LSB   = 0;
    localparam int CTRL_SIZE_W     = 3;
    localparam int CTRL_OFFSET_LSB = 8;
    localparam int CTRL_OFFSET_W   = 2;
    localparam int CTRL_CLR_BIT    = 16;

    // STATUS fields
    localparam int STATUS_DROP_LSB = 0;
    localparam int STATUS_DROP_W   = 8;
    localparam int STATUS_RX_LSB   = 8;
    localparam int STATUS_TX_LSB   = 16;

    // Interrupt sources
    localparam int IRQ_W = 5;

    // Bytes carried by one 32-bit word
    localparam logic [3:0] BYTES_PER_WORD = 4'd4;

    // Reset values
    localparam logic [CTRL_SIZE_W-1:0]   CTRL_SIZE_RST   = 3'd1;
    localparam logic [CTRL_OFFSET_W-1:0] CTRL_OFFSET_RST = 2'd0;
    localparam logic [IRQ_W-1:0]         IRQEN_RST       = '0;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    // A chunk must be 1..4 bytes and must not run past the end of the word.
    function automatic logic ctrl_legal(input logic [CTRL_SIZE_W-1:0]   size,
                                        input logic [CTRL_OFFSET_W-1:0] offset);
        logic [3:0] span;
        span = {1'b0, size} + {2'b00, offset};
        return (size != '0) && ({1'b0, size} <= BYTES_PER_WORD) && (span <= BYTES_PER_WORD);
    endfunction

endpackage

// File: rtl/apb_reg_slave.sv
// -----------------------------------------------------------------------------
// apb_reg_slave
// APB3 completer for the aligner configuration/status registers.
//
// Ports:
//   pclk, preset_n          clock, asynchronous active-low reset
//   paddr/pwrite/psel/penable/pwdata   APB request
//   pready/prdata/pslverr   APB response (all registered)
//   ctrl_size/ctrl_offset   CTRL fields to the datapath
//   ctrl_clr                one-cycle pulse after a CTRL write with CLR=1
//   cnt_drop/rx_lvl/tx_lvl  datapath status, read through STATUS
//   irq_set                 per-source interrupt set pulses
//   irq                     registered OR of (IRQ & IRQEN)
//
// Assumes LVLW <= 8 so the level fields fit their STATUS byte lanes.
// -----------------------------------------------------------------------------
module apb_reg_slave
    import apb_reg_pkg::*;
#(
    parameter int APB_MAX_ADDR_WIDTH = 16,
    parameter int APB_MAX_DATA_WIDTH = 32,
    parameter int WAIT_STATES        = 0,
    parameter int FIFO_DEPTH         = 8,
    localparam int LVLW              = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                          pclk,
    input  logic                          preset_n,
    input  logic [APB_MAX_ADDR_WIDTH-1:0] paddr,
    input  logic                          pwrite,
    input  logic                          psel,
    input  logic                          penable,
    input  logic [APB_MAX_DATA_WIDTH-1:0] pwdata,
    output logic                          pready,
    output logic [APB_MAX_DATA_WIDTH-1:0] prdata,
    output logic                          pslverr,
    output logic [2:0]                    ctrl_size,
    output logic [1:0]                    ctrl_offset,
    output logic                          ctrl_clr,
    input  logic [7:0]                    cnt_drop,
    input  logic [LVLW-1:0]               rx_lvl,
    input  logic [LVLW-1:0]               tx_lvl,
    input  logic [IRQ_W-1:0]              irq_set,
    output logic                          irq
);

    localparam int         AW = APB_MAX_ADDR_WIDTH;
    localparam int         DW = APB_MAX_DATA_WIDTH;
    localparam logic [4:0] WS = 5'(WAIT_STATES);

    apb_state_e      state;
    logic [3:0]      wait_cnt;
    logic [4:0]      wait_nxt;
    logic [AW-1:0]   addr_q;
    logic            write_q;
    logic [DW-1:0]   wdata_q;
    logic [IRQ_W-1:0] irqen_q;
    logic [IRQ_W-1:0] irq_q;

    logic [AW-1:0]   req_addr;
    logic            req_write;
    logic [DW-1:0]   req_wdata;
    logic            hit_ctrl, hit_status, hit_irqen, hit_irq;
    logic            req_err;
    logic [DW-1:0]   req_rdata;
    logic            setup;
    logic            commit;
    logic [IRQ_W-1:0] irq_w1c;
    logic            unused_wdata;

    // The response is registered, so with zero wait states it is computed
    // from the live bus during setup; otherwise from the latched request.
    always_comb begin
        req_addr  = addr_q;
        req_write = write_q;
        req_wdata = wdata_q;
        if (state == IDLE) begin
            req_addr  = paddr;
            req_write = pwrite;
            req_wdata = pwdata;
        end
    end

    assign setup    = psel && !penable;
    assign wait_nxt = {1'b0, wait_cnt} + 5'd1;

    assign hit_ctrl   = (req_addr == AW'(CTRL_OFF));
    assign hit_status = (req_addr == AW'(STATUS_OFF));
    assign hit_irqen  = (req_addr == AW'(IRQEN_OFF));
    assign hit_irq    = (req_addr == AW'(IRQ_OFF));

    always_comb begin
        req_err = 1'b0;
        if (req_addr[1:0] != 2'b00) begin
            req_err = 1'b1;
        end else if (!(hit_ctrl || hit_status || hit_irqen || hit_irq)) begin
            req_err = 1'b1;
        end else if (req_write && hit_status) begin
            req_err = 1'b1;
        end else if (req_write && hit_ctrl &&
                     !ctrl_legal(req_wdata[CTRL_SIZE_LSB +: CTRL_SIZE_W],
                                 req_wdata[CTRL_OFFSET_LSB +: CTRL_OFFSET_W])) begin
            req_err = 1'b1;
        end
    end

    // STATUS is sampled at the edge that launches the completion cycle.
    always_comb begin
        req_rdata = '0;
        if (hit_ctrl) begin
            req_rdata[CTRL_SIZE_LSB +: CTRL_SIZE_W]     = ctrl_size;
            req_rdata[CTRL_OFFSET_LSB +: CTRL_OFFSET_W] = ctrl_offset;
        end else if (hit_status) begin
            req_rdata[STATUS_DROP_LSB +: STATUS_DROP_W] = cnt_drop;
            req_rdata[STATUS_RX_LSB +: LVLW]            = rx_lvl;
            req_rdata[STATUS_TX_LSB +: LVLW]            = tx_lvl;
        end else if (hit_irqen) begin
            req_rdata[IRQ_W-1:0] = irqen_q;
        end else if (hit_irq) begin
            req_rdata[IRQ_W-1:0] = irq_q;
        end
    end

    // A write takes effect on the edge that ends the completion cycle;
    // pslverr already holds the verdict for this request.
    assign commit  = (state == ACCESS) && psel && pready && req_write && !pslverr;
    assign irq_w1c = (commit && hit_irq) ? req_wdata[IRQ_W-1:0] : '0;

    assign unused_wdata = ^{req_wdata[DW-1:CTRL_CLR_BIT+1],
                            req_wdata[CTRL_CLR_BIT-1:CTRL_OFFSET_LSB+CTRL_OFFSET_W],
                            req_wdata[CTRL_OFFSET_LSB-1:IRQ_W]};

    // Request capture: datapath only, no reset needed.
    always_ff @(posedge pclk) begin
        if (state == IDLE && setup) begin
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata;
        end
    end

    // APB completer FSM with registered response outputs.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            pready   <= 1'b0;
            prdata   <= '0;
            pslverr  <= 1'b0;
        end else begin
            pready  <= 1'b0;
            prdata  <= '0;
            pslverr <= 1'b0;
            case (state)
                IDLE: begin
                    if (setup) begin
                        state    <= ACCESS;
                        wait_cnt <= '0;
                        if (WS == 5'd0) begin
                            pready  <= 1'b1;
                            pslverr <= req_err;
                            prdata  <= (!req_write && !req_err) ? req_rdata : '0;
                        end
                    end
                end
                ACCESS: begin
                    if (!psel || pready) begin
                        // Aborted by the requester, or just completed.
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_nxt[3:0];
                        if (wait_nxt == WS) begin
                            pready  <= 1'b1;
                            pslverr <= req_err;
                            prdata  <= (!req_write && !req_err) ? req_rdata : '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register file, interrupt state and datapath controls.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            ctrl_size   <= CTRL_SIZE_RST;
            ctrl_offset <= CTRL_OFFSET_RST;
            ctrl_clr    <= 1'b0;
            irqen_q     <= IRQEN_RST;
            irq_q       <= '0;
            irq         <= 1'b0;
        end else begin
            ctrl_clr <= 1'b0;
            if (commit && hit_ctrl) begin
                ctrl_size   <= req_wdata[CTRL_SIZE_LSB +: CTRL_SIZE_W];
                ctrl_offset <= req_wdata[CTRL_OFFSET_LSB +: CTRL_OFFSET_W];
                ctrl_clr    <= req_wdata[CTRL_CLR_BIT];
            end
            if (commit && hit_irqen) begin
                irqen_q <= req_wdata[IRQ_W-1:0];
            end
            // Set is applied after clear so a coincident set wins.
            irq_q <= (irq_q & ~irq_w1c) | irq_set;
            irq   <= |(irq_q & irqen_q);
        end
    end

endmodule
